key_debounce_bank: RTL and testbench

Multi-channel, parametrised debouncer for the Tetris push-button and keypad inputs. It synchronises N raw mechanical inputs and filters each one with a shared sample tick and a per-channel stability counter. For every channel it produces a clean level, a one-cycle press pulse and a one-cycle release pulse. An optional hold-to-repeat mode adds extra press pulses so that held move and drop keys keep acting.

---
 rtl/key_debounce_bank.sv | 127 ++++++++++++
 tb/tb_key_debounce_bank.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/key_debounce_bank.sv
// N-channel debouncer: 2-flop sync, shared sample tick, per-channel stability counter, press/release pulses.
// Define DEBOUNCE_REPEAT_EN for hold-to-repeat presses; 'release' is a reserved word, so that port is release_pulse.
module key_debounce_bank #(
    parameter int CHANNELS       = 5,
    parameter int SAMPLE_DIV     = 12500,
    parameter int STABLE_SAMPLES = 4,
    parameter int REPEAT_DELAY   = 20,
    parameter int REPEAT_RATE    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse
);

    localparam int TW = $clog2(SAMPLE_DIV + 1);
    localparam int SW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_SAMPLES - 1);

    if (SAMPLE_DIV < 1 || STABLE_SAMPLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_cfg_check
        $error("key_debounce_bank: SAMPLE_DIV, STABLE_SAMPLES, REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    logic [TW-1:0]       tick_q, tick_d;
    logic                tick;
    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] rel_q, rel_d;
    logic [SW-1:0]       stab_q [CHANNELS];
    logic [SW-1:0]       stab_d [CHANNELS];

`ifdef DEBOUNCE_REPEAT_EN
    localparam int HW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [HW-1:0] HOLD_PRE    = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_RATE);

    logic [HW-1:0] hold_q [CHANNELS];
    logic [HW-1:0] hold_d [CHANNELS];
`endif

    always_comb begin
        tick    = (tick_q == TICK_LAST);
        tick_d  = tick ? '0 : tick_q + 1'b1;
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
    always_comb begin
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            stab_d[i] = stab_q[i];
            if (tick) begin
                if (sync2_q[i] == level_q[i]) begin
                    stab_d[i] = '0;
                end else if (stab_q[i] == STAB_LAST) begin
                    level_d[i] = ~level_q[i];
                    stab_d[i]  = '0;
                end else begin
                    stab_d[i] = stab_q[i] + 1'b1;
                end
            end
            press_d[i] = level_d[i] & ~level_q[i];
            rel_d[i]   = ~level_d[i] & level_q[i];
`ifdef DEBOUNCE_REPEAT_EN
            // Hold count restarts from 0 at the rise; a falling tick clears it without firing.
            hold_d[i] = hold_q[i];
            if (!level_q[i]) begin
                hold_d[i] = '0;
            end else if (tick) begin
                if (!level_d[i]) begin
                    hold_d[i] = '0;
                end else if (hold_q[i] == HOLD_PRE) begin
                    press_d[i] = 1'b1;
                    hold_d[i]  = HOLD_RELOAD;
                end else begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end
            end
`endif
        end
    end

    // NOTE: the per-channel counter arrays are reset too, since a stale count would shorten the first debounce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                stab_q[i] <= '0;
`ifdef DEBOUNCE_REPEAT_EN
                hold_q[i] <= '0;
`endif
            end
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
            tick_q  <= tick_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            for (int i = 0; i < CHANNELS; i++) begin
                stab_q[i] <= stab_d[i];
`ifdef DEBOUNCE_REPEAT_EN
                hold_q[i] <= hold_d[i];
`endif
            end
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = rel_q;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Scoreboard bench for key_debounce_bank: stimulus pushes expected pulse events, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_key_debounce_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] raw = 2'b00;
    logic [1:0] level, press, release_pulse;

    always #5 clk = ~clk;

    key_debounce_bank #(
        .CHANNELS(2), .SAMPLE_DIV(3), .STABLE_SAMPLES(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst(rst), .raw(raw),
        .level(level), .press(press), .release_pulse(release_pulse)
    );

    typedef struct {
        int         cyc;
        logic [1:0] p;
        logic [1:0] r;
        logic [1:0] l;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Cycle n = n-th rising edge since reset was released.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_event(input int c, input logic [1:0] p, input logic [1:0] r, input logic [1:0] l);
        exp_t e;
        e.cyc = c;
        e.p   = p;
        e.r   = r;
        e.l   = l;
        sb.push_back(e);
    endtask

    task automatic at_cycle(input int n);
        int guard = 0;
        while (cyc != n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) check("wait_cycle", cyc, n);
    endtask

    exp_t got_e;
    always @(negedge clk) begin
        if (!rst && (press != 2'b00 || release_pulse != 2'b00)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {press, release_pulse}, 0);
            end else begin
                got_e = sb.pop_front();
                check("event_cycle", cyc, got_e.cyc);
                check("event_press", press, got_e.p);
                check("event_release", release_pulse, got_e.r);
                check("event_level", level, got_e.l);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        raw = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_level", level, 0);
        check("reset_press", press, 0);
        check("reset_release", release_pulse, 0);

        // Both keys pressed, then reset asserted while level is high.
        at_cycle(1);
        raw = 2'b11;
        expect_event(12, 2'b11, 2'b00, 2'b11);
        at_cycle(14);
        check("level_before_reset", level, 3);
        rst = 1'b1;
        #1;
        check("async_reset_level", level, 0);
        check("async_reset_press", press, 0);
        check("async_reset_release", release_pulse, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        // raw held high through reset: reported as a fresh press.
        expect_event(12, 2'b11, 2'b00, 2'b11);

        at_cycle(14);
        raw = 2'b00;
        expect_event(28, 2'b00, 2'b11, 2'b00);

        // Clean press and release on channel 0.
        at_cycle(30);
        raw = 2'b01;
        expect_event(44, 2'b01, 2'b00, 2'b01);
        at_cycle(46);
        raw = 2'b00;
        expect_event(60, 2'b00, 2'b01, 2'b00);

        // Glitch: two ticks high, one tick low, then high again.
        at_cycle(62);
        raw = 2'b01;
        at_cycle(73);
        raw = 2'b00;
        at_cycle(77);
        raw = 2'b01;
        expect_event(88, 2'b01, 2'b00, 2'b01);
`ifdef DEBOUNCE_REPEAT_EN
        expect_event(104, 2'b01, 2'b00, 2'b01);
        expect_event(112, 2'b01, 2'b00, 2'b01);
        expect_event(120, 2'b01, 2'b00, 2'b01);
        expect_event(128, 2'b01, 2'b00, 2'b01);
        expect_event(136, 2'b01, 2'b00, 2'b01);
`endif
        at_cycle(86);
        check("glitch_level_low", level, 0);
        at_cycle(100);
        check("held_level", level, 1);
        // Level falls at hold tick 14: no repeat on the falling tick.
        at_cycle(133);
        raw = 2'b00;
        expect_event(144, 2'b00, 2'b01, 2'b00);

        // Simultaneous press on both channels, release only channel 1.
        at_cycle(150);
        raw = 2'b11;
        expect_event(164, 2'b11, 2'b00, 2'b11);
        at_cycle(166);
        raw = 2'b01;
`ifdef DEBOUNCE_REPEAT_EN
        expect_event(180, 2'b01, 2'b10, 2'b01);
        expect_event(188, 2'b01, 2'b00, 2'b01);
`else
        expect_event(180, 2'b00, 2'b10, 2'b01);
`endif
        at_cycle(182);
        raw = 2'b00;
        expect_event(196, 2'b00, 2'b01, 2'b00);

        at_cycle(210);
        check("pending_events", sb.size(), 0);
        check("final_level", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
